// File: rtl/ins_fetch_ctrl.sv
// Instruction fetch controller: host-fed instruction FIFO plus a run FSM that issues
// ins_num words to the dispatcher. Optional perf counters built with INS_FETCH_PERF_EN.
//   state   | meaning
//   IDLE    | waiting for start; FIFO still accepts pushes
//   RUN     | issuing words, one accept per ins_ready pulse
//   DRAIN   | all words issued, waiting for working low 2 cycles
//   DONE    | single cycle before returning to IDLE
module ins_fetch_ctrl #(
  parameter int INST_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [INST_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              start,
  input  logic [15:0]       ins_num,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INST_W-1:0] ins,
  input  logic              working,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [1:0]        r_state;
  logic [15:0]       r_remaining;
  logic [1:0]        r_drain_cnt;
  logic              r_ins_valid;
  logic              r_done;
  logic              r_err_ovf;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_start_ok;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push     = wr_en && !w_full;
  assign w_pop      = (r_state == S_RUN) && r_ins_valid && ins_ready;
  assign w_start_ok = start && (r_state == S_IDLE);

  assign wr_full   = w_full;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign err_ovf   = r_err_ovf;
  assign ins_valid = r_ins_valid && !ins_ready;
  assign ins       = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     r_err_ovf <= 1'b0;
    else if (w_start_ok)         r_err_ovf <= 1'b0;
    else if (wr_en && w_full)    r_err_ovf <= 1'b1;
  end

  // Valid re-arms only from the registered empty flag, so every pop leaves a gap cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_drain_cnt <= '0;
      r_ins_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= ins_num;
            r_state     <= (ins_num == 16'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (w_pop) begin
            r_ins_valid <= 1'b0;
            r_remaining <= r_remaining - 16'd1;
            if (r_remaining == 16'd1) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= 2'd2;
            end
          end else if (!r_ins_valid && !w_empty) begin
            r_ins_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (working)                  r_drain_cnt <= 2'd2;
          else if (r_drain_cnt == 2'd1) r_state     <= S_DONE;
          else                          r_drain_cnt <= r_drain_cnt - 2'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef INS_FETCH_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (busy && (r_perf_cycles != 32'hFFFF_FFFF))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_RUN) && r_ins_valid && !ins_ready && (r_perf_stall != 32'hFFFF_FFFF))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_stall  = r_perf_stall;
`else
  assign perf_cycles = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Directed testbench for ins_fetch_ctrl; perf expectations follow INS_FETCH_PERF_EN.
module tb_ins_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, wr_en, start, ins_ready, working;
  logic [63:0] wr_data, ins;
  logic [15:0] ins_num;
  logic        wr_full, busy, done, err_ovf, ins_valid;
  logic [31:0] perf_cycles, perf_stall;
  int n_pass = 0;
  int n_total = 0;

  ins_fetch_ctrl dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .start(start), .ins_num(ins_num), .busy(busy), .done(done), .err_ovf(err_ovf),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .working(working),
    .perf_cycles(perf_cycles), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    wr_en = 1'b1;
    wr_data = w;
    step();
    wr_en = 1'b0;
  endtask

  task automatic kick(input logic [15:0] n);
    start = 1'b1;
    ins_num = n;
    step();
    start = 1'b0;
  endtask

  // Waits for ins_valid, holds dly cycles, then pulses ins_ready; returns observations.
  task automatic get_word(input int dly, output logic [63:0] w, output bit ok,
                          output bit stable, output bit gated);
    int n;
    n = 0;
    ok = 1'b0;
    stable = 1'b1;
    gated = 1'b0;
    w = '0;
    while (n < 40 && ins_valid !== 1'b1) begin
      step();
      n++;
    end
    if (ins_valid !== 1'b1) return;
    ok = 1'b1;
    w = ins;
    for (int i = 0; i < dly; i++) begin
      step();
      if (ins !== w || ins_valid !== 1'b1) stable = 1'b0;
    end
    ins_ready = 1'b1;
    #1;
    gated = (ins_valid === 1'b0);
    step();
    ins_ready = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output bit saw_valid);
    int n;
    n = 0;
    saw_valid = 1'b0;
    while (n < 40 && done !== 1'b1) begin
      if (ins_valid === 1'b1) saw_valid = 1'b1;
      step();
      n++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; ins_num = '0;
    ins_ready = 1'b0; working = 1'b0;
    step(); step();
    n_total++; if (wr_full !== 1'b0) $display("FAIL reset_wr_full got %b want 0", wr_full); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (err_ovf !== 1'b0) $display("FAIL reset_err_ovf got %b want 0", err_ovf); else n_pass++;
    n_total++; if (ins_valid !== 1'b0) $display("FAIL reset_ins_valid got %b want 0", ins_valid); else n_pass++;
    n_total++; if (perf_cycles !== 32'd0 || perf_stall !== 32'd0)
      $display("FAIL reset_perf got %0d/%0d want 0/0", perf_cycles, perf_stall); else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [63:0] exp_w [3];
    logic [63:0] w;
    bit ok, st, gt;
    exp_w[0] = 64'hAAAA_0000_0000_0001;
    exp_w[1] = 64'hBBBB_0000_0000_0002;
    exp_w[2] = 64'hCCCC_0000_0000_0003;
    for (int i = 0; i < 3; i++) push(exp_w[i]);
    working = 1'b1;
    kick(16'd3);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy_run got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      get_word(2, w, ok, st, gt);
      n_total++; if (!ok) $display("FAIL basic_valid_timeout word %0d got none want valid", i); else n_pass++;
      n_total++; if (w !== exp_w[i]) $display("FAIL basic_ins word %0d got %h want %h", i, w, exp_w[i]); else n_pass++;
      n_total++; if (!st) $display("FAIL basic_stable word %0d got unstable want stable", i); else n_pass++;
      n_total++; if (!gt) $display("FAIL basic_gate word %0d got valid=1 in ready cycle want 0", i); else n_pass++;
      n_total++; if (ins_valid !== 1'b0) $display("FAIL basic_gap word %0d got %b want 0", i, ins_valid); else n_pass++;
    end
    step(); step();
    n_total++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_drain_hold got busy=%b done=%b want 1/0", busy, done); else n_pass++;
    working = 1'b0;
    step(); step();
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_early got %b want 0", done); else n_pass++;
    step();
    n_total++; if (done !== 1'b1) $display("FAIL basic_done got %b want 1", done); else n_pass++;
    step();
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] w;
    bit ok, st, gt, sv;
    for (int i = 0; i < 16; i++) push(64'h100 + 64'(i));
    n_total++; if (wr_full !== 1'b1) $display("FAIL ovf_full got %b want 1", wr_full); else n_pass++;
    n_total++; if (err_ovf !== 1'b0) $display("FAIL ovf_err_early got %b want 0", err_ovf); else n_pass++;
    push(64'hDEAD);
    n_total++; if (err_ovf !== 1'b1) $display("FAIL ovf_err got %b want 1", err_ovf); else n_pass++;
    step();
    n_total++; if (err_ovf !== 1'b1 || wr_full !== 1'b1)
      $display("FAIL ovf_sticky got err=%b full=%b want 1/1", err_ovf, wr_full); else n_pass++;
    kick(16'd16);
    n_total++; if (err_ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", err_ovf); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      get_word(0, w, ok, st, gt);
      n_total++; if (!ok || w !== 64'h100 + 64'(i))
        $display("FAIL ovf_word %0d got %h (ok=%b) want %h", i, w, ok, 64'h100 + 64'(i)); else n_pass++;
    end
    wait_done(ok, sv);
    n_total++; if (!ok || wr_full !== 1'b0)
      $display("FAIL ovf_done got done=%b full=%b want 1/0", ok, wr_full); else n_pass++;
    step();
  endtask

  task automatic test_zero();
    logic [63:0] w;
    bit ok, st, gt, sv;
    push(64'h5A5A_1234);
    kick(16'd0);
    n_total++; if (done !== 1'b0 || busy !== 1'b0 || ins_valid !== 1'b0)
      $display("FAIL zero_cycle1 got done=%b busy=%b valid=%b want 0/0/0", done, busy, ins_valid); else n_pass++;
    step();
    n_total++; if (done !== 1'b1 || ins_valid !== 1'b0)
      $display("FAIL zero_done got done=%b valid=%b want 1/0", done, ins_valid); else n_pass++;
    step();
    n_total++; if (done !== 1'b0) $display("FAIL zero_pulse got %b want 0", done); else n_pass++;
    kick(16'd1);
    get_word(1, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'h5A5A_1234)
      $display("FAIL zero_fifo_kept got %h (ok=%b) want 5a5a1234", w, ok); else n_pass++;
    wait_done(ok, sv);
    n_total++; if (!ok) $display("FAIL zero_run1_done got 0 want 1"); else n_pass++;
    step();
  endtask

  task automatic test_empty_start();
    logic [63:0] w;
    bit ok, st, gt, sv, seen;
    kick(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ins_valid !== 1'b0) seen = 1'b1;
      step();
    end
    n_total++; if (seen) $display("FAIL empty_no_valid got valid=1 want 0"); else n_pass++;
    push(64'h0000_0000_00AB_CDEF);
    n_total++; if (ins_valid !== 1'b0) $display("FAIL empty_no_bypass got %b want 0", ins_valid); else n_pass++;
    step();
    n_total++; if (ins_valid !== 1'b1 || ins !== 64'h00AB_CDEF)
      $display("FAIL empty_first got valid=%b ins=%h want 1/abcdef", ins_valid, ins); else n_pass++;
    wr_en = 1'b1; wr_data = 64'h0000_0000_0012_3456; ins_ready = 1'b1;
    step();
    wr_en = 1'b0; ins_ready = 1'b0;
    n_total++; if (ins_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL empty_pushpop_gap got valid=%b busy=%b want 0/1", ins_valid, busy); else n_pass++;
    get_word(1, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'h0012_3456)
      $display("FAIL empty_second got %h (ok=%b) want 123456", w, ok); else n_pass++;
    wait_done(ok, sv);
    n_total++; if (!ok || sv) $display("FAIL empty_done got done=%b extra_valid=%b want 1/0", ok, sv); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] w;
    bit ok, st, gt, sv;
    push(64'hB1); push(64'hB2); push(64'hB3);
    kick(16'd2);
    get_word(1, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hB1) $display("FAIL b2b_w1 got %h want b1", w); else n_pass++;
    kick(16'd5);
    get_word(1, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hB2) $display("FAIL b2b_w2 got %h want b2", w); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_drain_busy got %b want 1", busy); else n_pass++;
    wait_done(ok, sv);
    n_total++; if (!ok || sv)
      $display("FAIL b2b_start_ignored got done=%b extra_valid=%b want 1/0", ok, sv); else n_pass++;
    step();
    kick(16'd1);
    get_word(0, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hB3) $display("FAIL b2b_leftover got %h want b3", w); else n_pass++;
    wait_done(ok, sv);
    step();
  endtask

  task automatic test_rst_mid();
    logic [63:0] w;
    bit ok, st, gt, sv, seen;
    int n;
    for (int i = 0; i < 4; i++) push(64'hC0 + 64'(i));
    working = 1'b1;
    kick(16'd4);
    get_word(0, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hC0) $display("FAIL rst_first got %h want c0", w); else n_pass++;
    n = 0;
    while (n < 10 && ins_valid !== 1'b1) begin step(); n++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    working = 1'b0;
    n_total++; if (ins_valid !== 1'b0 || busy !== 1'b0 || wr_full !== 1'b0)
      $display("FAIL rst_state got valid=%b busy=%b full=%b want 0/0/0", ins_valid, busy, wr_full); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done !== 1'b0) seen = 1'b1;
      step();
    end
    n_total++; if (seen) $display("FAIL rst_no_done got done=1 want 0"); else n_pass++;
    kick(16'd1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ins_valid !== 1'b0) seen = 1'b1;
      step();
    end
    n_total++; if (seen) $display("FAIL rst_fifo_flushed got valid=1 want 0"); else n_pass++;
    push(64'hE7);
    get_word(0, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hE7) $display("FAIL rst_new_word got %h want e7", w); else n_pass++;
    wait_done(ok, sv);
    step();
  endtask

  task automatic test_perf();
    logic [63:0] w;
    bit ok, st, gt, sv;
    push(64'hF1); push(64'hF2);
    working = 1'b0;
    kick(16'd2);
    get_word(3, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hF1) $display("FAIL perf_w1 got %h want f1", w); else n_pass++;
    get_word(3, w, ok, st, gt);
    n_total++; if (!ok || w !== 64'hF2) $display("FAIL perf_w2 got %h want f2", w); else n_pass++;
    wait_done(ok, sv);
`ifdef INS_FETCH_PERF_EN
    n_total++; if (perf_stall !== 32'd6) $display("FAIL perf_stall got %0d want 6", perf_stall); else n_pass++;
    n_total++; if (perf_cycles !== 32'd12) $display("FAIL perf_cycles got %0d want 12", perf_cycles); else n_pass++;
    kick(16'd0);
    n_total++; if (perf_cycles !== 32'd0 || perf_stall !== 32'd0)
      $display("FAIL perf_clear got %0d/%0d want 0/0", perf_cycles, perf_stall); else n_pass++;
`else
    n_total++; if (perf_stall !== 32'd0) $display("FAIL perf_stall_off got %0d want 0", perf_stall); else n_pass++;
    n_total++; if (perf_cycles !== 32'd0) $display("FAIL perf_cycles_off got %0d want 0", perf_cycles); else n_pass++;
`endif
    step(); step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_empty_start();
    test_back_to_back();
    test_rst_mid();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
